// File: rtl/axi_burst_master.sv
// Burst master: turns one requester command into AR/R or AW/W/B traffic on the 8-bit memory slave bus.
// Latency: accept to ARVALID/AWVALID 1 cycle; R beat to rd_valid 1 cycle; done 1 cycle after the last R beat or B.
// Backpressure: cmd_ready only in IDLE; write beats stall on WREADY; rd_* cannot stall; any bus wait aborts after TIMEOUT cycles.
module axi_burst_master #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic [3:0]  cmd_id,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_err,
    output logic        rd_valid,
    output logic        rd_last,
    output logic        done,
    output logic [4:0]  done_resp,
    output logic        ARVALID,
    output logic [15:0] ARPKT,
    input  logic        ARREADY,
    input  logic        RVALID,
    output logic        RREADY,
    input  logic        RLAST,
    input  logic [8:0]  RDATA,
    output logic        AWVALID,
    output logic [11:0] AWPKT,
    input  logic        AWREADY,
    output logic        WVALID,
    input  logic        WREADY,
    output logic        WLAST,
    output logic [7:0]  WDATA,
    input  logic        BVALID,
    output logic        BREADY,
    input  logic [4:0]  BRESP
);

    typedef enum logic [2:0] {
        IDLE, AR_REQ, R_DATA, AW_REQ, W_DATA, B_WAIT, DONE
    } state_t;

    // Latched command; the direction only steers the first transition, so it is not kept.
    typedef struct packed {
        logic [7:0] addr;
        logic [3:0] len;
        logic [3:0] id;
    } cmd_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state;
    cmd_t          cmd_q;
    logic [3:0]    beat_cnt;
    logic          err;
    logic [TW-1:0] tmo_cnt;

    logic in_w;
    logic wait_st;
    logic hs_now;
    logic tmo_hit;
    logic r_hs;
    logic w_hs;
    logic r_last_beat;

    assign cmd_ready   = (state == IDLE);
    assign ARPKT       = {cmd_q.addr, cmd_q.len, cmd_q.id};
    assign AWPKT       = {cmd_q.addr, cmd_q.id};

    // Write beats pass straight through, gated so nothing leaks outside W_DATA.
    assign in_w        = (state == W_DATA);
    assign WVALID      = in_w & wr_valid;
    assign wr_ready    = in_w & WREADY;
    assign WDATA       = in_w ? wr_data : 8'h00;
    assign WLAST       = in_w && ((beat_cnt + 4'd1) == cmd_q.len);

    assign r_hs        = RVALID && RREADY;
    assign w_hs        = WVALID && WREADY;
    assign r_last_beat = RLAST || ((beat_cnt + 4'd1) == cmd_q.len);
    assign tmo_hit     = (tmo_cnt == TW'(TIMEOUT - 1));

    // Flag the bus-wait states and whether the awaited handshake happens this cycle.
    always_comb begin
        wait_st = 1'b0;
        hs_now  = 1'b0;
        case (state)
            AR_REQ:  begin wait_st = 1'b1; hs_now = ARVALID && ARREADY; end
            R_DATA:  begin wait_st = 1'b1; hs_now = r_hs;               end
            AW_REQ:  begin wait_st = 1'b1; hs_now = AWVALID && AWREADY; end
            W_DATA:  begin wait_st = 1'b1; hs_now = w_hs;               end
            B_WAIT:  begin wait_st = 1'b1; hs_now = BVALID && BREADY;   end
            default: ;
        endcase
    end

    // Command FSM with registered bus controls, requester strobes and timeout abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cmd_q     <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
            tmo_cnt   <= '0;
            ARVALID   <= 1'b0;
            AWVALID   <= 1'b0;
            RREADY    <= 1'b0;
            BREADY    <= 1'b0;
            rd_data   <= '0;
            rd_err    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            done      <= 1'b0;
            done_resp <= '0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b0;

            if (wait_st && !hs_now && tmo_hit) begin
                // Slave went quiet: release the bus and report the command as failed.
                ARVALID   <= 1'b0;
                AWVALID   <= 1'b0;
                RREADY    <= 1'b0;
                BREADY    <= 1'b0;
                tmo_cnt   <= '0;
                state     <= DONE;
                done      <= 1'b1;
                done_resp <= {1'b1, cmd_q.id};
            end else begin
                // Every handshake restarts the wait; entry to each wait state is itself a handshake edge.
                if (hs_now || !wait_st)
                    tmo_cnt <= '0;
                else
                    tmo_cnt <= tmo_cnt + TW'(1);

                case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            cmd_q    <= '{addr: cmd_addr, len: cmd_len, id: cmd_id};
                            beat_cnt <= '0;
                            err      <= 1'b0;
                            if (cmd_len == 4'd0) begin
                                state     <= DONE;
                                done      <= 1'b1;
                                done_resp <= {1'b1, cmd_id};
                            end else if (cmd_write) begin
                                state   <= AW_REQ;
                                AWVALID <= 1'b1;
                            end else begin
                                state   <= AR_REQ;
                                ARVALID <= 1'b1;
                            end
                        end
                    end
                    AR_REQ: begin
                        // ARVALID falls on the same edge RREADY rises, so the slave sees them disjoint.
                        if (ARREADY) begin
                            ARVALID <= 1'b0;
                            RREADY  <= 1'b1;
                            state   <= R_DATA;
                        end
                    end
                    R_DATA: begin
                        if (r_hs) begin
                            rd_data  <= RDATA[8:1];
                            rd_err   <= RDATA[0];
                            rd_valid <= 1'b1;
                            beat_cnt <= beat_cnt + 4'd1;
                            err      <= err | RDATA[0];
                            if (r_last_beat) begin
                                rd_last   <= 1'b1;
                                RREADY    <= 1'b0;
                                state     <= DONE;
                                done      <= 1'b1;
                                done_resp <= {err | RDATA[0], cmd_q.id};
                            end
                        end
                    end
                    AW_REQ: begin
                        if (AWREADY) begin
                            AWVALID <= 1'b0;
                            state   <= W_DATA;
                        end
                    end
                    W_DATA: begin
                        if (w_hs) begin
                            beat_cnt <= beat_cnt + 4'd1;
                            if (WLAST) begin
                                BREADY <= 1'b1;
                                state  <= B_WAIT;
                            end
                        end
                    end
                    B_WAIT: begin
                        // A response tagged with someone else's ID counts as an error too.
                        if (BVALID) begin
                            BREADY    <= 1'b0;
                            state     <= DONE;
                            done      <= 1'b1;
                            done_resp <= {err | BRESP[4] | (BRESP[3:0] != cmd_q.id), cmd_q.id};
                        end
                    end
                    DONE: begin
                        err      <= 1'b0;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: behavioural 8-bit memory slave, command table plus corner sequences.
// Read beats and completions are predicted at issue time and scored when the DUT emits them.
// Slave stalls are randomised except where a sequence needs exact cycle behaviour.
module tb_axi_burst_master;

    localparam int TIMEOUT = 64;
    localparam logic [63:0] RST_VEC = 64'h1000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic [3:0]  cmd_id = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_err;
    logic        rd_valid;
    logic        rd_last;
    logic        done;
    logic [4:0]  done_resp;
    logic        ARVALID;
    logic [15:0] ARPKT;
    logic        ARREADY = 1'b0;
    logic        RVALID = 1'b0;
    logic        RREADY;
    logic        RLAST = 1'b0;
    logic [8:0]  RDATA = '0;
    logic        AWVALID;
    logic [11:0] AWPKT;
    logic        AWREADY = 1'b0;
    logic        WVALID;
    logic        WREADY = 1'b0;
    logic        WLAST;
    logic [7:0]  WDATA;
    logic        BVALID = 1'b0;
    logic        BREADY;
    logic [4:0]  BRESP = '0;

    axi_burst_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_err(rd_err), .rd_valid(rd_valid), .rd_last(rd_last),
        .done(done), .done_resp(done_resp),
        .ARVALID(ARVALID), .ARPKT(ARPKT), .ARREADY(ARREADY),
        .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RDATA(RDATA),
        .AWVALID(AWVALID), .AWPKT(AWPKT), .AWREADY(AWREADY),
        .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WDATA(WDATA),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {3'b0, cmd_ready, ARVALID, AWVALID, WVALID, wr_ready, RREADY, BREADY, WLAST,
                rd_valid, rd_last, rd_err, done, done_resp, rd_data, WDATA, ARPKT, AWPKT};
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0] d;
        logic       e;
        logic       l;
    } beat_t;

    beat_t      rd_q[$];
    logic [4:0] done_q[$];
    int         done_cnt = 0;
    int         ar_cycles = 0;
    int         aw_cycles = 0;
    beat_t      got_beat;
    beat_t      exp_beat;

    // Monitor: sample registered outputs just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            if (rd_valid) begin
                got_beat = {rd_data, rd_err, rd_last};
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: beat 0x%0h with nothing expected", got_beat);
                end else begin
                    exp_beat = rd_q.pop_front();
                    check("rd_beat", 64'(got_beat), 64'(exp_beat));
                end
            end
            if (done) begin
                done_cnt++;
                check("done_cmd_ready", 64'(cmd_ready), 64'd0);
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: done_resp 0x%0h with nothing expected", done_resp);
                end else begin
                    check("done_resp", 64'(done_resp), 64'(done_q.pop_front()));
                end
            end
            if (ARVALID) ar_cycles++;
            if (AWVALID) aw_cycles++;
        end
    end

    // ---------------- slave model ----------------
    logic [7:0] smem    [256];
    logic [7:0] ref_mem [256];
    logic [8:0] r_addr = '0;
    logic [3:0] r_left = '0;
    logic [8:0] w_addr = '0;
    logic [3:0] w_id = '0;
    logic [7:0] w_dat_s = '0;
    bit         w_last_s, w_active, w_err, b_pend;
    bit         ar_hs, r_hs, aw_hs, w_hs, b_hs;
    int         w_beats = 0;
    bit         stall_en = 1'b0;
    bit         arready_block = 1'b0;
    logic [3:0] bresp_id_xor = '0;
    logic [3:0] rlast_at = '0;
    logic [3:0] cur_len = '0;

    function automatic bit stall();
        return stall_en && ($urandom_range(0, 3) == 0);
    endfunction

    // Slave: commit last edge's handshakes, then drive this cycle's responses.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            r_left = '0; w_active = 0; w_err = 0; b_pend = 0;
            ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
            ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = '0;
            AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0;
        end else begin
            if (ar_hs) begin
                r_addr = {1'b0, ARPKT[15:8]};
                r_left = (rlast_at != 0) ? rlast_at : ARPKT[7:4];
            end
            if (r_hs) begin
                r_addr = r_addr + 9'd1;
                r_left = r_left - 4'd1;
            end
            if (aw_hs) begin
                w_addr = {1'b0, AWPKT[11:4]};
                w_id = AWPKT[3:0];
                w_active = 1; w_err = 0; w_beats = 0;
            end
            if (w_hs) begin
                if (w_addr < 9'd256) smem[w_addr[7:0]] = w_dat_s;
                else w_err = 1;
                w_addr = w_addr + 9'd1;
                w_beats++;
                if (w_last_s) begin
                    w_active = 0;
                    b_pend = 1;
                end
            end
            if (b_hs) b_pend = 0;

            ARREADY = ARVALID && !arready_block && !stall();
            RVALID  = (r_left != 0) && RREADY && !ARVALID && !stall();
            RDATA   = (r_addr < 9'd256) ? {smem[r_addr[7:0]], 1'b0} : 9'h001;
            RLAST   = (r_left == 4'd1);
            AWREADY = AWVALID && !stall();
            WREADY  = w_active && !stall();
            BVALID  = b_pend;
            BRESP   = {w_err, w_id ^ bresp_id_xor};

            ar_hs = ARVALID && ARREADY;
            r_hs  = RVALID && RREADY;
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            b_hs  = BVALID && BREADY;
            w_dat_s  = WDATA;
            w_last_s = WLAST;
            if (w_hs) check("wlast", 64'(WLAST), 64'((w_beats + 1) == int'(cur_len)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_cmd(input bit wr, input logic [7:0] addr, input logic [3:0] len,
                           input logic [3:0] id, input logic [7:0] base, input int nbeats,
                           input logic [4:0] exp_resp);
        int         guard;
        int         sent;
        int         start_done;
        logic [8:0] a;
        beat_t      eb;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        if (!cmd_ready) return;
        if (!wr) begin
            for (int i = 0; i < nbeats; i++) begin
                a = 9'(addr) + 9'(i);
                eb.d = (a < 9'd256) ? ref_mem[a[7:0]] : 8'h00;
                eb.e = !(a < 9'd256);
                eb.l = (i == nbeats - 1);
                rd_q.push_back(eb);
            end
        end else begin
            for (int i = 0; i < int'(len); i++) begin
                a = 9'(addr) + 9'(i);
                if (a < 9'd256) ref_mem[a[7:0]] = 8'(base + 8'(i));
            end
        end
        done_q.push_back(exp_resp);
        cur_len = len;
        start_done = done_cnt;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
        @(negedge clk);
        cmd_valid = 0;
        check("busy_cmd_ready", 64'(cmd_ready), 64'd0);
        if (wr) begin
            sent = 0;
            guard = 0;
            while (sent < int'(len) && guard < 500) begin
                wr_valid = 1;
                wr_data = 8'(base + 8'(sent));
                #2;
                if (wr_ready) sent++;
                @(negedge clk);
                guard++;
            end
            wr_valid = 0;
            check("wr_beats_sent", 64'(sent), 64'(len));
        end
        guard = 0;
        while (done_cnt == start_done && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", 64'(done_cnt - start_done), 64'd1);
        check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [3:0] len;
        logic [3:0] id;
        logic [7:0] base;
        logic [4:0] exp_resp;
    } vec_t;

    vec_t tbl[9];
    int   sent_b;
    int   guard_b;

    initial begin
        tbl[0] = '{0, 8'h10, 4'd4,  4'h3, 8'h00, 5'h03};
        tbl[1] = '{1, 8'h20, 4'd3,  4'h5, 8'h0A, 5'h05};
        tbl[2] = '{0, 8'h20, 4'd3,  4'h5, 8'h00, 5'h05};
        tbl[3] = '{0, 8'hFE, 4'd4,  4'h7, 8'h00, 5'h17};
        tbl[4] = '{1, 8'h40, 4'd15, 4'hF, 8'h80, 5'h0F};
        tbl[5] = '{0, 8'h40, 4'd15, 4'hA, 8'h00, 5'h0A};
        tbl[6] = '{0, 8'h30, 4'd1,  4'h1, 8'h00, 5'h01};
        tbl[7] = '{1, 8'hFF, 4'd2,  4'h2, 8'h33, 5'h12};
        tbl[8] = '{0, 8'hFF, 4'd1,  4'h6, 8'h00, 5'h06};

        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'(i) ^ 8'h5A;
            smem[i] = 8'(i) ^ 8'h5A;
        end
        for (int i = 0; i < 4; i++) begin
            ref_mem[8'h10 + i] = 8'(i + 1);
            smem[8'h10 + i] = 8'(i + 1);
        end

        #2 rst = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), RST_VEC);
        rst = 1;

        // Command table with random slave stalls.
        stall_en = 1;
        for (int k = 0; k < 9; k++)
            run_cmd(tbl[k].wr, tbl[k].addr, tbl[k].len, tbl[k].id, tbl[k].base,
                    tbl[k].wr ? 0 : int'(tbl[k].len), tbl[k].exp_resp);

        // Zero-length commands never touch the bus.
        ar_cycles = 0;
        aw_cycles = 0;
        run_cmd(0, 8'h55, 4'd0, 4'h9, 8'h00, 0, 5'h19);
        run_cmd(1, 8'h55, 4'd0, 4'h2, 8'h00, 0, 5'h12);
        check("len0_arvalid_cycles", 64'(ar_cycles), 64'd0);
        check("len0_awvalid_cycles", 64'(aw_cycles), 64'd0);

        // ARREADY never comes: abort after exactly TIMEOUT cycles of ARVALID.
        stall_en = 0;
        arready_block = 1;
        ar_cycles = 0;
        run_cmd(0, 8'h10, 4'd4, 4'h6, 8'h00, 0, 5'h16);
        arready_block = 0;
        check("timeout_arvalid_cycles", 64'(ar_cycles), 64'(TIMEOUT));
        check("arvalid_after_timeout", 64'(ARVALID), 64'd0);

        // Slave ends the burst early with RLAST on beat 2 of 4.
        rlast_at = 4'd2;
        run_cmd(0, 8'h10, 4'd4, 4'h4, 8'h00, 2, 5'h04);
        rlast_at = 4'd0;

        // B response carrying a foreign ID is reported as an error.
        bresp_id_xor = 4'h1;
        run_cmd(1, 8'h60, 4'd2, 4'h4, 8'h70, 0, 5'h14);
        bresp_id_xor = 4'h0;

        // Reset while write beat 2 is being presented.
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h50; cmd_len = 4'd4; cmd_id = 4'h3;
        cur_len = 4'd4;
        @(negedge clk);
        cmd_valid = 0;
        sent_b = 0;
        guard_b = 0;
        while (sent_b < 1 && guard_b < 50) begin
            wr_valid = 1;
            wr_data = 8'hE1;
            #2;
            if (wr_ready) sent_b++;
            @(negedge clk);
            guard_b++;
        end
        wr_data = 8'hE2;
        #2;
        check("rst_beat2_ready", 64'(wr_ready), 64'd1);
        #1 rst = 0;
        #1 check("midburst_reset_outputs", outs(), RST_VEC);
        wr_valid = 0;
        @(negedge clk);
        #3 rst = 1;

        // Normal traffic resumes after the aborted burst.
        stall_en = 1;
        run_cmd(1, 8'h50, 4'd4, 4'h3, 8'h90, 0, 5'h03);
        run_cmd(0, 8'h50, 4'd4, 4'h3, 8'h00, 4, 5'h03);

        repeat (5) @(negedge clk);
        check("final_done_q_empty", 64'(done_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
